// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage register/flag
// inputs, register enable/flush controls, FSM status and perf counters.
// The pipeline side uses master and the controller uses slave.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_W         = 32
);
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID;
  logic                      rs1_used_ID;
  logic                      rs2_used_ID;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_EX;
  logic                      RegWrite_EX;
  logic                      MemRead_EX;
  logic                      mc_op_EX;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_MEM;
  logic                      RegWrite_MEM;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_WB;
  logic                      RegWrite_WB;
  logic                      redirect_i;
  logic                      pc_en;
  logic                      if_id_en;
  logic                      if_id_flush;
  logic                      id_ex_en;
  logic                      id_ex_flush;
  logic                      ex_mem_flush;
  logic                      mc_busy;
  logic [PERF_W-1:0]         stall_cnt;
  logic [PERF_W-1:0]         flush_cnt;

  modport master (
    output rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
    output rd_addr_EX, RegWrite_EX, MemRead_EX, mc_op_EX,
    output rd_addr_MEM, RegWrite_MEM, rd_addr_WB, RegWrite_WB, redirect_i,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush,
    input  mc_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
    input  rd_addr_EX, RegWrite_EX, MemRead_EX, mc_op_EX,
    input  rd_addr_MEM, RegWrite_MEM, rd_addr_WB, RegWrite_WB, redirect_i,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush,
    output mc_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32I pipeline. Controls are
// combinational from the stage inputs and the multi-cycle FSM state.
// Priority: rst > redirect > multi-cycle occupancy > RAW stall > normal.
// There is no valid/ready handshake here: every input is a level that
// describes the current cycle, every output applies to the current cycle.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH       = 5,
  parameter int BRANCH_RESOLVE_STAGE = 3,
  parameter int FORWARD_EN           = 1,
  parameter int MC_LAT               = 4,
  parameter int PERF_W               = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int CW = $clog2(MC_LAT);
  localparam logic [CW-1:0]     MC_LOAD   = CW'(MC_LAT - 2);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1);
  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        BUSY      = 1'b1;

  logic [0:0]        state_q;
  logic [CW-1:0]     cnt_q;
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  logic m_ex, m_mem, m_wb;
  logic hz_lu, hz_nf, mc_stall;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;

  // x0 is hard-wired zero, so a write to it can never create a hazard
  function automatic logic src_match(input logic [REG_ADDR_WIDTH-1:0] rd);
    src_match = (rd != '0) &&
                ((bus.rs1_used_ID && (bus.rs1_addr_ID == rd)) ||
                 (bus.rs2_used_ID && (bus.rs2_addr_ID == rd)));
  endfunction

  // RAW detection against each older stage and multi-cycle occupancy
  always_comb begin
    m_ex  = src_match(bus.rd_addr_EX);
    m_mem = src_match(bus.rd_addr_MEM);
    m_wb  = src_match(bus.rd_addr_WB);
    hz_lu = bus.MemRead_EX && bus.RegWrite_EX && m_ex;
    hz_nf = (FORWARD_EN == 0) &&
            ((bus.RegWrite_EX && m_ex) || (bus.RegWrite_MEM && m_mem) ||
             (bus.RegWrite_WB && m_wb));
    // The final BUSY cycle (cnt=0) releases EX so the result can move on
    mc_stall = ((state_q == BUSY) && (cnt_q != '0)) ||
               ((state_q == IDLE) && bus.mc_op_EX);
  end

  // Prioritised enable/flush generation
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (bus.redirect_i) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      // Resolving in MEM means the EX instruction is also on the wrong path
      ex_mem_flush = (BRANCH_RESOLVE_STAGE == 3);
    end else if (mc_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (hz_lu || hz_nf) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Multi-cycle FSM; a redirect squashes the op occupying EX
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (bus.redirect_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (bus.mc_op_EX) begin
        state_q <= BUSY;
        cnt_q   <= MC_LOAD;
      end
    end else if (cnt_q == '0) begin
      state_q <= IDLE;
    end else begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + PERF_ONE;
      if (bus.redirect_i && (flush_q != '1)) flush_q <= flush_q + PERF_ONE;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mc_busy      = (state_q == BUSY) && !rst;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Three instances share one stimulus:
//   a: defaults (forwarding, MEM resolve, MC_LAT=4, 32-bit counters)
//   b: FORWARD_EN=0
//   c: PERF_W=4, resolve in EX, MC_LAT=2
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, rd_ex, rd_mem, rd_wb;
  logic u1, u2, rw_ex, mr_ex, mc_op, rw_mem, rw_wb, redir;

  pipeline_hazard_ctrl_if bus_a ();
  pipeline_hazard_ctrl_if bus_b ();
  pipeline_hazard_ctrl_if #(.PERF_W(4)) bus_c ();

  assign bus_a.rs1_addr_ID = rs1;    assign bus_b.rs1_addr_ID = rs1;    assign bus_c.rs1_addr_ID = rs1;
  assign bus_a.rs2_addr_ID = rs2;    assign bus_b.rs2_addr_ID = rs2;    assign bus_c.rs2_addr_ID = rs2;
  assign bus_a.rs1_used_ID = u1;     assign bus_b.rs1_used_ID = u1;     assign bus_c.rs1_used_ID = u1;
  assign bus_a.rs2_used_ID = u2;     assign bus_b.rs2_used_ID = u2;     assign bus_c.rs2_used_ID = u2;
  assign bus_a.rd_addr_EX  = rd_ex;  assign bus_b.rd_addr_EX  = rd_ex;  assign bus_c.rd_addr_EX  = rd_ex;
  assign bus_a.RegWrite_EX = rw_ex;  assign bus_b.RegWrite_EX = rw_ex;  assign bus_c.RegWrite_EX = rw_ex;
  assign bus_a.MemRead_EX  = mr_ex;  assign bus_b.MemRead_EX  = mr_ex;  assign bus_c.MemRead_EX  = mr_ex;
  assign bus_a.mc_op_EX    = mc_op;  assign bus_b.mc_op_EX    = mc_op;  assign bus_c.mc_op_EX    = mc_op;
  assign bus_a.rd_addr_MEM = rd_mem; assign bus_b.rd_addr_MEM = rd_mem; assign bus_c.rd_addr_MEM = rd_mem;
  assign bus_a.RegWrite_MEM = rw_mem; assign bus_b.RegWrite_MEM = rw_mem; assign bus_c.RegWrite_MEM = rw_mem;
  assign bus_a.rd_addr_WB  = rd_wb;  assign bus_b.rd_addr_WB  = rd_wb;  assign bus_c.rd_addr_WB  = rd_wb;
  assign bus_a.RegWrite_WB = rw_wb;  assign bus_b.RegWrite_WB = rw_wb;  assign bus_c.RegWrite_WB = rw_wb;
  assign bus_a.redirect_i  = redir;  assign bus_b.redirect_i  = redir;  assign bus_c.redirect_i  = redir;

  pipeline_hazard_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipeline_hazard_ctrl #(.FORWARD_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  pipeline_hazard_ctrl #(.PERF_W(4), .BRANCH_RESOLVE_STAGE(2), .MC_LAT(2))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  int total = 0;
  int bad   = 0;

  // Expected output bit order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush}
  typedef struct {
    logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd_ex; logic rw_ex; logic mr_ex;
    logic [4:0] rd_mem; logic rw_mem; logic [4:0] rd_wb; logic rw_wb;
    logic redir;
    logic [5:0] exp_a; logic exp_b_pc; logic [5:0] exp_c;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] ctl_a();
    return {bus_a.pc_en, bus_a.if_id_en, bus_a.if_id_flush,
            bus_a.id_ex_en, bus_a.id_ex_flush, bus_a.ex_mem_flush};
  endfunction

  function automatic logic [5:0] ctl_c();
    return {bus_c.pc_en, bus_c.if_id_en, bus_c.if_id_flush,
            bus_c.id_ex_en, bus_c.id_ex_flush, bus_c.ex_mem_flush};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0;
    rd_ex = '0; rw_ex = 1'b0; mr_ex = 1'b0; mc_op = 1'b0;
    rd_mem = '0; rw_mem = 1'b0; rd_wb = '0; rw_wb = 1'b0; redir = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; checks the reset-state outputs while rst is held
  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    check("rst_ctl_a", ctl_a(), 6'b111111);
    check("rst_busy_a", bus_a.mc_busy, 0);
    check("rst_stall_a", bus_a.stall_cnt, 0);
    check("rst_flush_a", bus_a.flush_cnt, 0);
    check("rst_flush_c", bus_c.flush_cnt, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  logic [4:0] mc_pc_a   = 5'b11000;
  logic [4:0] mc_busy_a = 5'b01110;
  logic [4:0] mc_emf_a  = 5'b00111;
  logic [4:0] mc_iden_a = 5'b11000;
  logic [4:0] mc_pc_c   = 5'b11010;
  logic [4:0] mc_busy_c = 5'b01010;
  logic [3:0] nf_pc_b   = 4'b1000;

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110100, 1'b1, 6'b110100};
    vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000110, 1'b0, 6'b000110};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110100, 1'b1, 6'b110100};
    vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110100, 1'b1, 6'b110100};
    vecs[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000110, 1'b0, 6'b000110};
    vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110100, 1'b0, 6'b110100};
    vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110100, 1'b1, 6'b110100};
    vecs[7]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 6'b110100, 1'b0, 6'b110100};
    vecs[8]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 6'b110100, 1'b0, 6'b110100};
    vecs[9]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 6'b110100, 1'b1, 6'b110100};
    vecs[10] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b111111, 1'b1, 6'b111110};
    vecs[11] = '{5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b111111, 1'b1, 6'b111110};

    reset_dut();

    // Combinational vectors, FSM idle throughout
    for (int i = 0; i < 12; i++) begin
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
      rd_ex = vecs[i].rd_ex; rw_ex = vecs[i].rw_ex; mr_ex = vecs[i].mr_ex;
      rd_mem = vecs[i].rd_mem; rw_mem = vecs[i].rw_mem;
      rd_wb = vecs[i].rd_wb; rw_wb = vecs[i].rw_wb; redir = vecs[i].redir;
      #2;
      check($sformatf("vec%0d_a", i), ctl_a(), vecs[i].exp_a);
      check($sformatf("vec%0d_b_pc", i), bus_b.pc_en, vecs[i].exp_b_pc);
      check($sformatf("vec%0d_c", i), ctl_c(), vecs[i].exp_c);
      next_cycle();
    end

    // Load-use stall lasts one cycle and counts once; x0 never stalls
    reset_dut();
    rs2 = 5'd5; u2 = 1'b1; rd_ex = 5'd5; rw_ex = 1'b1; mr_ex = 1'b1;
    #2 check("lu_pc", bus_a.pc_en, 0);
    next_cycle();
    clear_inputs();
    #2 check("lu_release", bus_a.pc_en, 1);
    check("lu_stall_cnt", bus_a.stall_cnt, 1);
    next_cycle();
    rs2 = 5'd0; u2 = 1'b1; rd_ex = 5'd0; rw_ex = 1'b1; mr_ex = 1'b1;
    #2 check("lu_x0_pc", bus_a.pc_en, 1);
    next_cycle();
    clear_inputs();
    #2 check("lu_x0_stall_cnt", bus_a.stall_cnt, 1);

    // Multi-cycle op held in EX until released
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      mc_op = (i < 4);
      #2;
      check($sformatf("mc%0d_pc_a", i), bus_a.pc_en, mc_pc_a[i]);
      check($sformatf("mc%0d_busy_a", i), bus_a.mc_busy, mc_busy_a[i]);
      check($sformatf("mc%0d_emf_a", i), bus_a.ex_mem_flush, mc_emf_a[i]);
      check($sformatf("mc%0d_iden_a", i), bus_a.id_ex_en, mc_iden_a[i]);
      check($sformatf("mc%0d_pc_c", i), bus_c.pc_en, mc_pc_c[i]);
      check($sformatf("mc%0d_busy_c", i), bus_c.mc_busy, mc_busy_c[i]);
      next_cycle();
    end
    #2 check("mc_stall_cnt", bus_a.stall_cnt, 3);

    // Redirect during BUSY aborts the op
    reset_dut();
    mc_op = 1'b1;
    next_cycle();
    redir = 1'b1;
    #2 check("rd_busy_ctl_a", ctl_a(), 6'b111111);
    check("rd_busy_still_a", bus_a.mc_busy, 1);
    check("rd_busy_emf_c", bus_c.ex_mem_flush, 0);
    next_cycle();
    mc_op = 1'b0; redir = 1'b0;
    #2 check("rd_abort_busy", bus_a.mc_busy, 0);
    check("rd_abort_pc", bus_a.pc_en, 1);
    check("rd_flush_cnt", bus_a.flush_cnt, 1);
    check("rd_stall_cnt", bus_a.stall_cnt, 1);

    // No-forward: producer x7 walks EX, MEM, WB
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      rs1 = 5'd7; u1 = 1'b1;
      rd_ex  = (i == 0) ? 5'd7 : 5'd0; rw_ex  = (i == 0);
      rd_mem = (i == 1) ? 5'd7 : 5'd0; rw_mem = (i == 1);
      rd_wb  = (i == 2) ? 5'd7 : 5'd0; rw_wb  = (i == 2);
      #2;
      check($sformatf("nf%0d_pc_b", i), bus_b.pc_en, nf_pc_b[i]);
      check($sformatf("nf%0d_pc_a", i), bus_a.pc_en, 1);
      next_cycle();
    end
    #2 check("nf_stall_cnt_b", bus_b.stall_cnt, 3);
    check("nf_stall_cnt_a", bus_a.stall_cnt, 0);

    // Redirect coincident with load-use: no stall
    reset_dut();
    rs2 = 5'd5; u2 = 1'b1; rd_ex = 5'd5; rw_ex = 1'b1; mr_ex = 1'b1; redir = 1'b1;
    #2 check("rlu_pc", bus_a.pc_en, 1);
    check("rlu_ifid_flush", bus_a.if_id_flush, 1);
    check("rlu_ifid_en", bus_a.if_id_en, 1);
    next_cycle();
    clear_inputs();
    #2 check("rlu_stall_cnt", bus_a.stall_cnt, 0);
    check("rlu_flush_cnt", bus_a.flush_cnt, 1);

    // Counter saturation, then reset in the middle of BUSY
    reset_dut();
    redir = 1'b1;
    for (int i = 0; i < 20; i++) next_cycle();
    redir = 1'b0;
    #2 check("sat_flush_c", bus_c.flush_cnt, 15);
    check("sat_flush_a", bus_a.flush_cnt, 20);
    next_cycle();
    mc_op = 1'b1;
    next_cycle();
    #2 check("pre_rst_busy", bus_a.mc_busy, 1);
    reset_dut();
    #2 check("post_rst_busy", bus_a.mc_busy, 0);
    check("post_rst_pc", bus_a.pc_en, 1);
    check("post_rst_flush_c", bus_c.flush_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
